arf038b064e1r1w0cbbehraa4acw_swt_obs_unload: RTL and testbench

Reader side of the Scan Write-Thru observation path. Samples the XOR-compressed observation vector produced by the phase-B observation flops, optionally compacts it over many cycles in a MISR, then serializes a snapshot LSB-first over a valid/ready bit stream to the test controller. It sits in the array wrapper between the observation flops and the DFx unload logic, and runs on the array port clock.

---
 rtl/arf038b064e1r1w0cbbehraa4acw_swt_obs_pkg.sv | 16 +
 rtl/arf038b064e1r1w0cbbehraa4acw_swt_obs_unload_if.sv | 28 ++
 rtl/arf038b064e1r1w0cbbehraa4acw_swt_obs_misr.sv | 41 ++++
 rtl/arf038b064e1r1w0cbbehraa4acw_swt_obs_unload.sv | 87 ++++++++
 tb/tb_arf038b064e1r1w0cbbehraa4acw_swt_obs_unload.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/arf038b064e1r1w0cbbehraa4acw_swt_obs_pkg.sv
// Shared types and constants for the Scan Write-Thru observation unload path.
// Holds the unload FSM states, the default MISR taps and the snapshot source encodings.
package arf038b064e1r1w0cbbehraa4acw_swt_obs_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int OBS_FLOP_NUM_DEF = 13;
   localparam logic [OBS_FLOP_NUM_DEF-1:0] MISR_POLY_DEF = 13'h001B;

   localparam logic CAPTURE_SEL_OBS = 1'b0;
   localparam logic CAPTURE_SEL_SIG = 1'b1;

endpackage

// File: rtl/arf038b064e1r1w0cbbehraa4acw_swt_obs_unload_if.sv
// Bundle of the observation inputs, MISR controls and serial unload stream.
// The unload block attaches through the slave modport; the controller side uses master.
interface arf038b064e1r1w0cbbehraa4acw_swt_obs_unload_if #(
   parameter int OBS_FLOP_NUM = 13
);
   logic [OBS_FLOP_NUM-1:0] obs_in;
   logic                    misr_en;
   logic                    misr_clear;
   logic                    capture_req;
   logic                    capture_sel;
   logic                    shift_ready;
   logic                    shift_valid;
   logic                    shift_data;
   logic                    shift_last;
   logic                    busy;
   logic                    capture_drop;
   logic [OBS_FLOP_NUM-1:0] signature;

   modport slave (
      input  obs_in, misr_en, misr_clear, capture_req, capture_sel, shift_ready,
      output shift_valid, shift_data, shift_last, busy, capture_drop, signature
   );

   modport master (
      output obs_in, misr_en, misr_clear, capture_req, capture_sel, shift_ready,
      input  shift_valid, shift_data, shift_last, busy, capture_drop, signature
   );
endinterface

// File: rtl/arf038b064e1r1w0cbbehraa4acw_swt_obs_misr.sv
// Multiple-input signature register compacting the observation vector over many cycles.
// Clear takes priority over fold; otherwise the signature holds.
module arf038b064e1r1w0cbbehraa4acw_swt_obs_misr
   import arf038b064e1r1w0cbbehraa4acw_swt_obs_pkg::*;
#(
   parameter int                      OBS_FLOP_NUM = OBS_FLOP_NUM_DEF,
   parameter logic [OBS_FLOP_NUM-1:0] MISR_POLY    = OBS_FLOP_NUM'(MISR_POLY_DEF)
) (
   input  logic                    clock,
   input  logic                    reset_b,
   input  logic                    misr_en_i,
   input  logic                    misr_clear_i,
   input  logic [OBS_FLOP_NUM-1:0] obs_in_i,
   output logic [OBS_FLOP_NUM-1:0] signature_o
);

   logic [OBS_FLOP_NUM-1:0] signature_q;
   logic [OBS_FLOP_NUM-1:0] signature_d;

   always_comb begin
      signature_d = signature_q;
      if (misr_clear_i) begin
         signature_d = '0;
      end else if (misr_en_i) begin
         signature_d = {signature_q[OBS_FLOP_NUM-2:0], 1'b0}
                     ^ (signature_q[OBS_FLOP_NUM-1] ? MISR_POLY : '0)
                     ^ obs_in_i;
      end
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         signature_q <= '0;
      end else begin
         signature_q <= signature_d;
      end
   end

   assign signature_o = signature_q;

endmodule

// File: rtl/arf038b064e1r1w0cbbehraa4acw_swt_obs_unload.sv
// Observation unload: snapshots obs_in or the MISR signature and streams it LSB-first
// over a valid/ready bit stream; requests arriving mid-unload are dropped and flagged.
module arf038b064e1r1w0cbbehraa4acw_swt_obs_unload
   import arf038b064e1r1w0cbbehraa4acw_swt_obs_pkg::*;
#(
   parameter int                      OBS_FLOP_NUM = OBS_FLOP_NUM_DEF,
   parameter logic [OBS_FLOP_NUM-1:0] MISR_POLY    = OBS_FLOP_NUM'(MISR_POLY_DEF)
) (
   input  logic                                     clock,
   input  logic                                     reset_b,
   arf038b064e1r1w0cbbehraa4acw_swt_obs_unload_if.slave bus
);

   localparam int CNT_W = $clog2(OBS_FLOP_NUM);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OBS_FLOP_NUM - 1);

   state_t                  state_q, state_d;
   logic [OBS_FLOP_NUM-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    drop_q, drop_d;
   logic [OBS_FLOP_NUM-1:0] signature;

   arf038b064e1r1w0cbbehraa4acw_swt_obs_misr #(
      .OBS_FLOP_NUM (OBS_FLOP_NUM),
      .MISR_POLY    (MISR_POLY)
   ) u_misr (
      .clock        (clock),
      .reset_b      (reset_b),
      .misr_en_i    (bus.misr_en),
      .misr_clear_i (bus.misr_clear),
      .obs_in_i     (bus.obs_in),
      .signature_o  (signature)
   );

   // The signature fed to the snapshot is the registered value, i.e. before this cycle's fold.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      count_d = count_q;
      drop_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.capture_req) begin
               case (bus.capture_sel)
                  CAPTURE_SEL_OBS: shreg_d = bus.obs_in;
                  default:         shreg_d = signature;
               endcase
               count_d = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            drop_d = bus.capture_req;
            if (bus.shift_ready) begin
               shreg_d = {1'b0, shreg_q[OBS_FLOP_NUM-1:1]};
               count_d = count_q + CNT_W'(1);
               if (count_q == LAST_IDX) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         state_q <= IDLE;
         shreg_q <= '0;
         count_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         count_q <= count_d;
         drop_q  <= drop_d;
      end
   end

   assign bus.shift_valid  = (state_q == SHIFT);
   assign bus.shift_data   = (state_q == SHIFT) & shreg_q[0];
   assign bus.shift_last   = (state_q == SHIFT) & (count_q == LAST_IDX);
   assign bus.busy         = (state_q == SHIFT);
   assign bus.capture_drop = drop_q;
   assign bus.signature    = signature;

endmodule

// File: tb/tb_arf038b064e1r1w0cbbehraa4acw_swt_obs_unload.sv
// Directed self-checking bench for the observation unload block.
// Expected bit streams and signatures are hand-computed constants.
module tb_arf038b064e1r1w0cbbehraa4acw_swt_obs_unload;

   logic clock;
   logic reset_b;
   int   checkCount;
   int   failCount;

   arf038b064e1r1w0cbbehraa4acw_swt_obs_unload_if #(.OBS_FLOP_NUM(13)) bus ();

   arf038b064e1r1w0cbbehraa4acw_swt_obs_unload dut (
      .clock   (clock),
      .reset_b (reset_b),
      .bus     (bus)
   );

   // Free-running array port clock, 10 time units per cycle.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compares one observed value against its expectation and tallies the result.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
      end
   endtask

   // Advances one clock and settles just after the rising edge.
   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_valid"}, 32'(bus.shift_valid), 32'd0);
      checkOutput({tag, "_data"}, 32'(bus.shift_data), 32'd0);
      checkOutput({tag, "_last"}, 32'(bus.shift_last), 32'd0);
      checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
      checkOutput({tag, "_drop"}, 32'(bus.capture_drop), 32'd0);
   endtask

   // Directed sequence: reset, raw unload, backpressure, MISR, overrun, reset mid-shift.
   initial begin
      int rawBits[13] = '{1, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1};
      int sigBits[13] = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      int fiveBits[13] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      checkCount = 0;
      failCount  = 0;
      reset_b = 1'b1;
      bus.obs_in = '0;
      bus.misr_en = 1'b0;
      bus.misr_clear = 1'b0;
      bus.capture_req = 1'b0;
      bus.capture_sel = 1'b0;
      bus.shift_ready = 1'b0;
      #1 reset_b = 1'b0;
      #1;
      checkIdleOutputs("reset");
      checkOutput("reset_sig", 32'(bus.signature), 32'h0);
      applyStimulus();
      applyStimulus();
      reset_b = 1'b1;
      applyStimulus();

      // Raw unload at full rate.
      bus.obs_in = 13'h1A5B;
      bus.capture_sel = 1'b0;
      bus.capture_req = 1'b1;
      bus.shift_ready = 1'b1;
      applyStimulus();
      bus.capture_req = 1'b0;
      bus.obs_in = 13'h0000;
      for (int i = 0; i < 13; i++) begin
         checkOutput($sformatf("raw_valid%0d", i), 32'(bus.shift_valid), 32'd1);
         checkOutput($sformatf("raw_bit%0d", i), 32'(bus.shift_data), 32'(rawBits[i]));
         checkOutput($sformatf("raw_last%0d", i), 32'(bus.shift_last), (i == 12) ? 32'd1 : 32'd0);
         checkOutput($sformatf("raw_busy%0d", i), 32'(bus.busy), 32'd1);
         applyStimulus();
      end
      checkIdleOutputs("raw_end");

      // Backpressure: ready low for one cycle, then high, for every bit.
      bus.obs_in = 13'h1A5B;
      bus.capture_req = 1'b1;
      applyStimulus();
      bus.capture_req = 1'b0;
      bus.obs_in = 13'h1FFF;
      for (int i = 0; i < 13; i++) begin
         bus.shift_ready = 1'b0;
         checkOutput($sformatf("bp_bitA%0d", i), 32'(bus.shift_data), 32'(rawBits[i]));
         applyStimulus();
         checkOutput($sformatf("bp_hold%0d", i), 32'(bus.shift_data), 32'(rawBits[i]));
         checkOutput($sformatf("bp_holdv%0d", i), 32'(bus.shift_valid), 32'd1);
         checkOutput($sformatf("bp_holdl%0d", i), 32'(bus.shift_last), (i == 12) ? 32'd1 : 32'd0);
         bus.shift_ready = 1'b1;
         applyStimulus();
      end
      checkIdleOutputs("bp_end");

      // MISR fold, feedback, clear priority and hold.
      bus.misr_clear = 1'b1;
      applyStimulus();
      checkOutput("misr_clear", 32'(bus.signature), 32'h0);
      bus.misr_clear = 1'b0;
      bus.misr_en = 1'b1;
      bus.obs_in = 13'h0001;
      applyStimulus();
      checkOutput("misr_fold1", 32'(bus.signature), 32'h0001);
      bus.obs_in = 13'h1000;
      applyStimulus();
      checkOutput("misr_fold2", 32'(bus.signature), 32'h1002);
      bus.misr_clear = 1'b1;
      applyStimulus();
      checkOutput("misr_clear_wins", 32'(bus.signature), 32'h0);
      bus.misr_clear = 1'b0;
      applyStimulus();
      checkOutput("misr_load1000", 32'(bus.signature), 32'h1000);
      bus.obs_in = 13'h0000;
      applyStimulus();
      checkOutput("misr_feedback", 32'(bus.signature), 32'h001B);
      bus.misr_en = 1'b0;
      bus.obs_in = 13'h1555;
      applyStimulus();
      checkOutput("misr_hold", 32'(bus.signature), 32'h001B);

      // Signature capture in the same cycle as a fold, with overrun requests.
      bus.capture_sel = 1'b1;
      bus.capture_req = 1'b1;
      bus.misr_en = 1'b1;
      bus.obs_in = 13'h0F0F;
      applyStimulus();
      bus.misr_en = 1'b0;
      checkOutput("cap_sig_fold", 32'(bus.signature), 32'h0F39);
      for (int i = 0; i < 13; i++) begin
         checkOutput($sformatf("sig_bit%0d", i), 32'(bus.shift_data), 32'(sigBits[i]));
         checkOutput($sformatf("sig_last%0d", i), 32'(bus.shift_last), (i == 12) ? 32'd1 : 32'd0);
         bus.capture_req = (i == 4 || i == 12);
         applyStimulus();
         checkOutput($sformatf("sig_drop%0d", i), 32'(bus.capture_drop), (i == 4 || i == 12) ? 32'd1 : 32'd0);
      end
      bus.capture_req = 1'b0;
      checkOutput("overrun_busy", 32'(bus.busy), 32'd0);
      applyStimulus();
      checkIdleOutputs("overrun_end");

      // Reset in the middle of a raw unload.
      bus.capture_sel = 1'b0;
      bus.obs_in = 13'h1A5B;
      bus.capture_req = 1'b1;
      applyStimulus();
      bus.capture_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("rst_pre_bit%0d", i), 32'(bus.shift_data), 32'(rawBits[i]));
         applyStimulus();
      end
      checkOutput("rst_pre_busy", 32'(bus.busy), 32'd1);
      #2 reset_b = 1'b0;
      #1;
      checkIdleOutputs("rst_mid");
      checkOutput("rst_mid_sig", 32'(bus.signature), 32'h0);
      applyStimulus();
      reset_b = 1'b1;
      bus.obs_in = 13'h0005;
      bus.capture_req = 1'b1;
      applyStimulus();
      bus.capture_req = 1'b0;
      for (int i = 0; i < 13; i++) begin
         checkOutput($sformatf("post_bit%0d", i), 32'(bus.shift_data), 32'(fiveBits[i]));
         checkOutput($sformatf("post_last%0d", i), 32'(bus.shift_last), (i == 12) ? 32'd1 : 32'd0);
         applyStimulus();
      end
      checkIdleOutputs("post_end");

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
